// File: rtl/stb_gen.sv
// Measures the period of sig_i over 2^AVG_LOG2 rising edges, then free-runs a dithered 1-clock strobe.
// Define STB_GEN_SIG_SYNC_EN to put a 2-flop synchronizer in front of the edge detector.
`timescale 1ns/1ps
module stb_gen #(
  parameter int unsigned T_CNT_WIDTH = 32,
  parameter int unsigned AVG_LOG2    = 3,
  parameter int unsigned MIN_PERIOD  = 2
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   sig_i,
  input  logic                   run_det_i,
  input  logic                   oe_i,
  output logic                   stb_o,
  output logic                   rdy_o,
  output logic                   err_o,
  output logic [T_CNT_WIDTH-1:0] stb_period_o
);

  localparam int unsigned EC_W  = AVG_LOG2 + 1;
  localparam int unsigned N_AVG = 1 << AVG_LOG2;

  typedef enum logic [2:0] {IDLE, ARM, WAIT_EDGE, MEASURE, RUN, ERR} state_t;

  state_t                 r_state, w_state_nxt;
  logic [T_CNT_WIDTH-1:0] r_total, w_total_nxt;
  logic [EC_W-1:0]        r_edge_cnt, w_edge_cnt_nxt;
  logic [T_CNT_WIDTH-1:0] r_ivl, w_ivl_nxt;
  logic [AVG_LOG2-1:0]    r_acc, w_acc_nxt;
  logic [AVG_LOG2-1:0]    r_frac, w_frac_nxt;
  logic [T_CNT_WIDTH-1:0] r_period, w_period_nxt;
  logic                   r_rdy, w_rdy_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_stb, w_stb_nxt;
  logic                   r_sig_d, r_edge;
  logic                   w_sig;

  logic [T_CNT_WIDTH-1:0] w_total_inc;
  logic [EC_W-1:0]        w_edge_cnt_inc;
  logic [T_CNT_WIDTH-1:0] w_meas_period;
  logic [AVG_LOG2-1:0]    w_meas_frac;
  logic [EC_W-1:0]        w_acc_sum;

`ifdef STB_GEN_SIG_SYNC_EN
  logic r_sync1, r_sync2;

  // Two-flop synchronizer for a truly asynchronous comparator output
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sig_i;
      r_sync2 <= r_sync1;
    end
  end
  assign w_sig = r_sync2;
`else
  assign w_sig = sig_i;
`endif

  // Registered rising-edge detector
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      r_sig_d <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sig_d <= w_sig;
      r_edge  <= w_sig & ~r_sig_d;
    end
  end

  assign w_total_inc    = r_total + T_CNT_WIDTH'(1);
  assign w_edge_cnt_inc = r_edge_cnt + EC_W'(1);
  assign w_meas_period  = w_total_inc >> AVG_LOG2;
  assign w_meas_frac    = w_total_inc[AVG_LOG2-1:0];
  assign w_acc_sum      = {1'b0, r_acc} + {1'b0, r_frac};

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      r_state    <= IDLE;
      r_total    <= '0;
      r_edge_cnt <= '0;
      r_ivl      <= '0;
      r_acc      <= '0;
      r_frac     <= '0;
      r_period   <= '0;
      r_rdy      <= 1'b0;
      r_err      <= 1'b0;
      r_stb      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_total    <= w_total_nxt;
      r_edge_cnt <= w_edge_cnt_nxt;
      r_ivl      <= w_ivl_nxt;
      r_acc      <= w_acc_nxt;
      r_frac     <= w_frac_nxt;
      r_period   <= w_period_nxt;
      r_rdy      <= w_rdy_nxt;
      r_err      <= w_err_nxt;
      r_stb      <= w_stb_nxt & oe_i;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    w_state_nxt    = r_state;
    w_total_nxt    = r_total;
    w_edge_cnt_nxt = r_edge_cnt;
    w_ivl_nxt      = r_ivl;
    w_acc_nxt      = r_acc;
    w_frac_nxt     = r_frac;
    w_period_nxt   = r_period;
    w_rdy_nxt      = r_rdy;
    w_err_nxt      = r_err;
    w_stb_nxt      = 1'b0;

    if (run_det_i) begin
      w_state_nxt    = ARM;
      w_total_nxt    = '0;
      w_edge_cnt_nxt = '0;
      w_ivl_nxt      = '0;
      w_acc_nxt      = '0;
      w_rdy_nxt      = 1'b0;
      w_err_nxt      = 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        ARM: w_state_nxt = WAIT_EDGE;
        WAIT_EDGE: begin
          if (r_edge) begin
            w_total_nxt    = '0;
            w_edge_cnt_nxt = '0;
            w_state_nxt    = MEASURE;
          end
        end
        MEASURE: begin
          if (r_total == '1) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ERR;
          end else begin
            w_total_nxt = w_total_inc;
            if (r_edge) begin
              w_edge_cnt_nxt = w_edge_cnt_inc;
              if (w_edge_cnt_inc == EC_W'(N_AVG)) begin
                if (w_meas_period < T_CNT_WIDTH'(MIN_PERIOD)) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ERR;
                end else begin
                  // First strobe next cycle; accumulator starts at 0 so this add never carries
                  w_period_nxt = w_meas_period;
                  w_frac_nxt   = w_meas_frac;
                  w_acc_nxt    = w_meas_frac;
                  w_ivl_nxt    = w_meas_period;
                  w_rdy_nxt    = 1'b1;
                  w_stb_nxt    = 1'b1;
                  w_state_nxt  = RUN;
                end
              end
            end
          end
        end
        RUN: begin
          if (r_ivl == T_CNT_WIDTH'(1)) begin
            w_stb_nxt = 1'b1;
            w_acc_nxt = w_acc_sum[AVG_LOG2-1:0];
            w_ivl_nxt = r_period + T_CNT_WIDTH'(w_acc_sum[AVG_LOG2]);
          end else begin
            w_ivl_nxt = r_ivl - T_CNT_WIDTH'(1);
          end
        end
        ERR: begin
          w_rdy_nxt = 1'b0;
          w_err_nxt = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign stb_o        = r_stb;
  assign rdy_o        = r_rdy;
  assign err_o        = r_err;
  assign stb_period_o = r_period;

endmodule

// File: tb/tb_stb_gen.sv
// Randomized bench for stb_gen: strobe times predicted from sig_i edge times, plus error and control cases.
`timescale 1ns/1ps
module tb_stb_gen;

`ifdef STB_GEN_SIG_SYNC_EN
  localparam longint LAT = 3;
`else
  localparam longint LAT = 1;
`endif
  localparam longint NAVG  = 8;
  localparam longint TCLK  = 8000;

  logic        clk   = 1'b0;
  logic        arst  = 1'b1;
  logic        sig_a = 1'b0, run_a = 1'b0, oe_a = 1'b1;
  logic        stb_a, rdy_a, err_a;
  logic [31:0] per_a;
  logic        sig_b = 1'b0, run_b = 1'b0, oe_b = 1'b1;
  logic        stb_b, rdy_b, err_b;
  logic [7:0]  per_b;

  longint cyc    = 0;
  int     n_cmp  = 0;
  int     n_bad  = 0;
  int     nb_stb = 0;
  longint stb_q[$];
  longint rise_q[$];
  longint rise_b_q[$];
  longint g_s0, g_total;

  stb_gen u_dut (
    .clk_i(clk), .arst_i(arst), .sig_i(sig_a), .run_det_i(run_a), .oe_i(oe_a),
    .stb_o(stb_a), .rdy_o(rdy_a), .err_o(err_a), .stb_period_o(per_a)
  );

  stb_gen #(.T_CNT_WIDTH(8), .AVG_LOG2(3), .MIN_PERIOD(3)) u_dut8 (
    .clk_i(clk), .arst_i(arst), .sig_i(sig_b), .run_det_i(run_b), .oe_i(oe_b),
    .stb_o(stb_b), .rdy_o(rdy_b), .err_o(err_b), .stb_period_o(per_b)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stb_a) stb_q.push_back(cyc);
    if (stb_b) nb_stb <= nb_stb + 1;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint now_ps();
    return longint'($realtime * 1000.0);
  endfunction

  // Cycle in which the edge detector reports a rise of sig_i at time t (ps)
  function automatic longint det_cycle(input longint t);
    return (t - TCLK / 2) / TCLK + 1 + LAT;
  endfunction

  function automatic int cnt_after(input longint c);
    int n = 0;
    foreach (stb_q[i]) if (stb_q[i] > c) n++;
    return n;
  endfunction

  function automatic bit on_grid(input longint s, input longint s0, input longint tot);
    longint g;
    for (int k = 0; k < 100000; k++) begin
      g = s0 + (longint'(k) * tot) / NAVG;
      if (g == s) return 1'b1;
      if (g > s) return 1'b0;
    end
    return 1'b0;
  endfunction

  // n pulses of width per/2, rising at t0 + k*per (all times in ps)
  task automatic drive(input bit which, input longint t0, input longint per, input int n);
    longint t;
    for (int k = 0; k < n; k++) begin
      t = t0 + longint'(k) * per;
      #(real'(t - now_ps()) / 1000.0);
      if (which) begin sig_b = 1'b1; rise_b_q.push_back(t); end
      else       begin sig_a = 1'b1; rise_q.push_back(t);   end
      #(real'((per / 4) * 2) / 1000.0);
      if (which) sig_b = 1'b0;
      else       sig_a = 1'b0;
    end
  endtask

  task automatic pulse_run(input bit which);
    @(negedge clk);
    if (which) run_b = 1'b1; else run_a = 1'b1;
    repeat (3) @(negedge clk);
    if (which) run_b = 1'b0; else run_a = 1'b0;
  endtask

  task automatic run_trial(input string tag, input longint per);
    longint t0, c0, c8, tot, budget, d;
    longint n;
    pulse_run(1'b0);
    stb_q.delete();
    rise_q.delete();
    t0     = now_ps() + 5 * TCLK + 2 * longint'($urandom_range(0, 3999)) + 1;
    budget = (per / TCLK) * 14 + 100;
    fork
      drive(1'b0, t0, per, 12);
      begin
        n = 0;
        while (!(rdy_a || err_a) && n < budget) begin @(negedge clk); n++; end
        n = 0;
        while (stb_q.size() < 12 && n < budget) begin @(negedge clk); n++; end
      end
    join
    c0  = det_cycle(rise_q[0]);
    c8  = det_cycle(rise_q[8]);
    tot = c8 - c0;
    chk($sformatf("%s.rdy", tag), longint'(rdy_a), 1);
    chk($sformatf("%s.err", tag), longint'(err_a), 0);
    chk($sformatf("%s.period", tag), longint'(per_a), tot / NAVG);
    chk($sformatf("%s.nstb", tag), longint'(stb_q.size()), 12);
    for (int k = 0; k < 12 && k < stb_q.size(); k++)
      chk($sformatf("%s.stb%0d", tag, k), stb_q[k], c8 + 1 + (longint'(k) * tot) / NAVG);
    for (int k = 0; k + 1 < stb_q.size() && k < 11; k++) begin
      d = (stb_q[k+1] - stb_q[k]) * TCLK - per;
      chk($sformatf("%s.ivl%0d_within_clk", tag, k), longint'((d < 0 ? -d : d) < TCLK), 1);
    end
    if (stb_q.size() >= 9) chk($sformatf("%s.sum8", tag), stb_q[8] - stb_q[0], tot);
    g_s0    = c8 + 1;
    g_total = tot;
  endtask

  task automatic trial_b(input string tag, input longint per);
    longint t0, tot, p;
    longint n;
    pulse_run(1'b1);
    rise_b_q.delete();
    t0 = now_ps() + 5 * TCLK + 1;
    fork
      drive(1'b1, t0, per, 9);
      begin
        n = 0;
        while (!(rdy_b || err_b) && n < 400) begin @(negedge clk); n++; end
      end
    join
    tot = det_cycle(rise_b_q[8]) - det_cycle(rise_b_q[0]);
    p   = tot / NAVG;
    chk($sformatf("%s.err", tag), longint'(err_b), longint'(p < 3));
    chk($sformatf("%s.rdy", tag), longint'(rdy_b), longint'(p >= 3));
    if (p >= 3) chk($sformatf("%s.period", tag), longint'(per_b), p);
  endtask

  initial begin
    longint c_off, c_on, c_rd, c0, n;
    int nb0;

    repeat (3) @(negedge clk);
    chk("rst.stb", longint'(stb_a), 0);
    chk("rst.rdy", longint'(rdy_a), 0);
    chk("rst.err", longint'(err_a), 0);
    chk("rst.period", longint'(per_a), 0);
    chk("rst8.err", longint'(err_b), 0);
    chk("rst8.period", longint'(per_b), 0);
    arst = 1'b0;

    run_trial("t200", 200000);

    // Gate the strobe off, then back on: resumed strobes stay on the original grid
    @(negedge clk);
    oe_a  = 1'b0;
    c_off = cyc;
    repeat (80) @(negedge clk);
    chk("oe.off_cnt", longint'(cnt_after(c_off)), 0);
    oe_a = 1'b1;
    c_on = cyc;
    n = 0;
    while (cnt_after(c_on) < 3 && n < 200) begin @(negedge clk); n++; end
    chk("oe.resume_cnt", longint'(cnt_after(c_on)), 3);
    foreach (stb_q[i])
      if (stb_q[i] > c_on) chk("oe.grid", longint'(on_grid(stb_q[i], g_s0, g_total)), 1);

    // Restart request during RUN kills the strobe and rdy, keeps the period
    @(negedge clk);
    run_a = 1'b1;
    c_rd  = cyc;
    repeat (2) @(negedge clk);
    chk("abort.rdy", longint'(rdy_a), 0);
    chk("abort.period", longint'(per_a), g_total / NAVG);
    repeat (40) @(negedge clk);
    chk("abort.stb", longint'(cnt_after(c_rd)), 0);
    run_a = 1'b0;

    for (int i = 0; i < 5; i++)
      run_trial($sformatf("rnd%0d", i), 2 * longint'($urandom_range(12000, 1200000)));

    // Reset while running
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    chk("rstrun.stb", longint'(stb_a), 0);
    chk("rstrun.rdy", longint'(rdy_a), 0);
    chk("rstrun.err", longint'(err_a), 0);
    chk("rstrun.period", longint'(per_a), 0);
    arst = 1'b0;

    run_trial("t8000", 8000000 + 2 * longint'($urandom_range(0, 3999)));

    // 8-bit counter: single edge then silence must overflow
    pulse_run(1'b1);
    rise_b_q.delete();
    nb0 = nb_stb;
    c0  = det_cycle(now_ps() + 5 * TCLK + 1);
    drive(1'b1, now_ps() + 5 * TCLK + 1, 100000, 1);
    n = 0;
    while (cyc < c0 + 256 && n < 1000) begin @(negedge clk); n++; end
    chk("ovf.early", longint'(err_b), 0);
    @(negedge clk);
    chk("ovf.err", longint'(err_b), 1);
    chk("ovf.rdy", longint'(rdy_b), 0);
    chk("ovf.stb", longint'(nb_stb - nb0), 0);
    pulse_run(1'b1);
    chk("ovf.clr", longint'(err_b), 0);

    trial_b("minp_low", 20000);
    trial_b("minp_ok", 28000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stb_gen.md
Name: stb_gen

Overview:
- Measures the period of an asynchronous periodic pulse train on sig_i (comparator output) over 2^AVG_LOG2 periods.
- After measurement it free-runs a 1-clock strobe on stb_o at that period. Fractional-clock dithering keeps every strobe interval within one clock of the true period.
- Sits in the measure unit and provides the timing reference for downstream sampling once the external signal is removed.

Parameters:
- T_CNT_WIDTH, 32, width of the clock-cycle counters and of stb_period_o.
- AVG_LOG2, 3, log2 of the number of sig_i periods averaged; also the width of the fractional phase accumulator.
- MIN_PERIOD, 2, smallest legal integer period in clocks; anything smaller is an error.

Ports:
- clk_i  in  1  system clock.
- arst_i  in  1  reset; synchronous, active-high (name kept per codebase convention).
- sig_i  in  1  asynchronous periodic input; rising edges are measured.
- run_det_i  in  1  detection restart; level-sensitive.
- oe_i  in  1  strobe output enable.
- stb_o  out  1  generated strobe, one clock wide.
- rdy_o  out  1  measurement complete, strobe running.
- err_o  out  1  measurement failed.
- stb_period_o  out  T_CNT_WIDTH  measured integer period in clocks.

Behaviour:
- Reset (sampled on clk_i edge with arst_i=1):
  - state=IDLE; stb_o=0, rdy_o=0, err_o=0, stb_period_o=0.
  - All counters, the phase accumulator and the synchronizer cleared.
- Input path:
  - sig_i passes through the input stage (see Optional Feature), then a registered rising-edge detector.
  - "edge" below means the 1-cycle detector output.
- States: IDLE, ARM, WAIT_EDGE, MEASURE, RUN, ERR.
- run_det_i=1 in any state:
  - go to ARM; clear rdy_o, err_o, counters and accumulator.
  - stb_o stays 0.
  - stb_period_o holds its last value.
- ARM: stays while run_det_i=1; on run_det_i=0, go to WAIT_EDGE.
- WAIT_EDGE:
  - waits indefinitely, no timeout.
  - On edge: total=0, edge_cnt=0, go to MEASURE.
- MEASURE:
  - total increments every clock, including the cycle of the closing edge.
  - On each edge, edge_cnt increments.
  - When edge_cnt reaches 2^AVG_LOG2, total = clocks from first-edge cycle to last-edge cycle. Then:
    - stb_period_o = total >> AVG_LOG2; frac = total[AVG_LOG2-1:0].
    - rdy_o=1; go to RUN.
    - The first strobe is asserted in the next cycle.
  - If total would wrap past all-ones: err_o=1, go to ERR.
  - If stb_period_o < MIN_PERIOD at completion: err_o=1, go to ERR.
- RUN:
  - Interval counter reloads at each strobe.
  - Each interval = stb_period_o + carry. The carry comes out of phase_acc (AVG_LOG2 bits), and phase_acc += frac at every strobe.
  - Intervals therefore alternate between P and P+1 clocks and average total/2^AVG_LOG2 exactly, with no drift.
  - sig_i is ignored in RUN.
  - Phase is locked to the last measured edge: first strobe = last edge-detect cycle + 1 clock.
- ERR: stb_o=0, rdy_o=0, err_o=1 held until run_det_i or reset.
- oe_i:
  - stb_o = internal strobe AND oe_i.
  - The internal timing always runs, so toggling oe_i never shifts phase.
- Reset mid-operation wins over everything and returns to IDLE.
- run_det_i=1 in RUN aborts the strobes within 1 clock.

Optional Feature:
- Macro STB_GEN_SIG_SYNC_EN.
- Defined: sig_i goes through a 2-flop synchronizer before edge detection. Fixed latency sig_i→edge is 3 clocks; strobes lag the true signal phase by that constant.
- Undefined: sig_i feeds the edge detector directly, for an already-synchronous source. Latency is 1 clock.
- Period measurement is identical in both cases.

Test Plan:
- Clock 8 ns; 20 ns-wide sig_i pulses, period 200 ns; run_det_i high 333 ns then low → stb_period_o=25, rdy_o=1, err_o=0, every strobe interval exactly 200 ns.
- Same setup, periods 20000 ns and 200000 ns → stb_period_o=2500 and 25000 respectively; after rdy_o, sig_i stopped; 11 consecutive strobe intervals each within 8 ns of the true period.
- Period 1333333 ns (166666.625 clocks) → stb_period_o=166666, frac=5; intervals mix of 166666 and 166667 clocks; every interval error below 8 ns; 8-interval sum exact.
- T_CNT_WIDTH=8, one sig_i edge then silence → err_o=1 after 256 clocks, rdy_o=0, stb_o stays 0; run_det_i pulse clears err_o.
- oe_i=0 during RUN → stb_o=0; re-assert oe_i → strobes resume on the original phase grid.
- arst_i=1 during RUN → next clock all outputs 0, state IDLE; stb_period_o=0.
